// File: rtl/sobel_result_framer.sv
// Sobel result framer: reduces 24-bit filter results to an 8-bit edge value,
// tags them with raster eol/eof flags and buffers them in a 2-entry FIFO.
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_result_vld/_data, o_result_busy   input handshake from the filter
//   o_pix_vld/_data/_eol/_eof, i_pix_busy output handshake to the pixel writer
//   o_frame_done, o_frame_cnt      frame completion pulse and counter
module sobel_result_framer #(
   parameter int WIDTH    = 640,
   parameter int HEIGHT   = 480,
   parameter int THRESH   = 128,
   parameter int BINARIZE = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_result_vld,
   input  logic [23:0] i_result_data,
   output logic        o_result_busy,
   output logic        o_pix_vld,
   output logic [7:0]  o_pix_data,
   output logic        o_pix_eol,
   output logic        o_pix_eof,
   input  logic        i_pix_busy,
   output logic        o_frame_done,
   output logic [15:0] o_frame_cnt
);
   localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   typedef struct packed {
      logic [7:0] pix;
      logic       eol;
      logic       eof;
   } ent_t;

   ent_t          mem_q [2];
   logic          wr_q, wr_d;
   logic          rd_q, rd_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          busy_q;
   logic          done_q, done_d;
   logic [15:0]   fcnt_q, fcnt_d;

   logic [7:0]    mag, pix;
   logic          last_x, last_y;
   logic          push, pop;
   ent_t          head;

   // Edge magnitude is the largest of the three channels.
   always_comb begin
      mag = i_result_data[23:16];
      if (i_result_data[15:8] > mag) mag = i_result_data[15:8];
      if (i_result_data[7:0] > mag)  mag = i_result_data[7:0];
      if (BINARIZE != 0)
         pix = (mag >= 8'(THRESH)) ? 8'hFF : 8'h00;
      else
         pix = mag;
   end

   assign last_x = (x_q == XW'(WIDTH - 1));
   assign last_y = (y_q == YW'(HEIGHT - 1));
   assign head   = mem_q[rd_q];
   assign push   = i_result_vld & ~busy_q;
   assign pop    = o_pix_vld & ~i_pix_busy;

   always_comb begin
      cnt_d  = cnt_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      x_d    = x_q;
      y_d    = y_q;
      done_d = 1'b0;
      fcnt_d = fcnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
      if (push) begin
         wr_d = ~wr_q;
         if (last_x) begin
            x_d = '0;
            y_d = last_y ? '0 : y_q + YW'(1);
         end else begin
            x_d = x_q + XW'(1);
         end
      end
      if (pop) begin
         rd_d = ~rd_q;
         if (head.eof) begin
            done_d = 1'b1;
            fcnt_d = fcnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         cnt_q    <= 2'd0;
         x_q      <= '0;
         y_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         fcnt_q   <= 16'd0;
      end else begin
         if (push) mem_q[wr_q] <= '{pix: pix, eol: last_x,
                                    eof: last_x & last_y};
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         x_q    <= x_d;
         y_q    <= y_d;
         // Busy is a flop so the filter never sees a path from i_pix_busy.
         busy_q <= (cnt_d == 2'd2);
         done_q <= done_d;
         fcnt_q <= fcnt_d;
      end
   end

   assign o_result_busy = busy_q;
   assign o_pix_vld     = (cnt_q != 2'd0);
   assign o_pix_data    = o_pix_vld ? head.pix : 8'h00;
   assign o_pix_eol     = o_pix_vld & head.eol;
   assign o_pix_eof     = o_pix_vld & head.eof;
   assign o_frame_done  = done_q;
   assign o_frame_cnt   = fcnt_q;
endmodule

// File: tb/tb_sobel_result_framer.sv
// Bench for sobel_result_framer: binarized and raw instances side by side,
// random data checked against a queue model of the framer.
module tb_sobel_result_framer;
   localparam int W = 4;
   localparam int H = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        vld;
   logic [23:0] din;
   logic        pbusy;

   logic        b_busy, b_vld, b_eol, b_eof, b_done;
   logic [7:0]  b_data;
   logic [15:0] b_fcnt;
   logic        r_busy, r_vld, r_eol, r_eof, r_done;
   logic [7:0]  r_data;
   logic [15:0] r_fcnt;

   always #5 clk = ~clk;

   sobel_result_framer #(.WIDTH(W), .HEIGHT(H), .THRESH(128), .BINARIZE(1)) u_bin (
      .i_clk(clk), .i_rst(rst), .i_result_vld(vld), .i_result_data(din),
      .o_result_busy(b_busy), .o_pix_vld(b_vld), .o_pix_data(b_data),
      .o_pix_eol(b_eol), .o_pix_eof(b_eof), .i_pix_busy(pbusy),
      .o_frame_done(b_done), .o_frame_cnt(b_fcnt));

   sobel_result_framer #(.WIDTH(W), .HEIGHT(H), .THRESH(128), .BINARIZE(0)) u_raw (
      .i_clk(clk), .i_rst(rst), .i_result_vld(vld), .i_result_data(din),
      .o_result_busy(r_busy), .o_pix_vld(r_vld), .o_pix_data(r_data),
      .o_pix_eol(r_eol), .o_pix_eof(r_eof), .i_pix_busy(pbusy),
      .o_frame_done(r_done), .o_frame_cnt(r_fcnt));

   typedef struct packed {
      logic [7:0] b;
      logic [7:0] r;
      logic       eol;
      logic       eof;
   } exp_t;

   exp_t q[$];
   int   n_in;
   int   frames;
   bit   done_exp;
   int   total = 0;
   int   bad = 0;
   int   pulses;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [23:0] d, input int n);
      exp_t e;
      int   m;
      int   k;
      m = d[23:16];
      if (d[15:8] > m) m = d[15:8];
      if (d[7:0] > m) m = d[7:0];
      k = n % (W * H);
      e.r   = 8'(m);
      e.b   = (m >= 128) ? 8'hFF : 8'h00;
      e.eol = (k % W) == W - 1;
      e.eof = k == W * H - 1;
      return e;
   endfunction

   task automatic check_out();
      chk("vld", 32'(b_vld), 32'(q.size() != 0));
      chk("raw_vld", 32'(r_vld), 32'(q.size() != 0));
      chk("busy", 32'(b_busy), 32'(q.size() == 2));
      chk("raw_busy", 32'(r_busy), 32'(q.size() == 2));
      if (q.size() != 0) begin
         chk("bin_data", 32'(b_data), 32'(q[0].b));
         chk("raw_data", 32'(r_data), 32'(q[0].r));
         chk("eol", 32'(b_eol), 32'(q[0].eol));
         chk("eof", 32'(b_eof), 32'(q[0].eof));
      end
      chk("done", 32'(b_done), 32'(done_exp));
      chk("fcnt", 32'(b_fcnt), 32'(frames & 16'hFFFF));
      chk("raw_fcnt", 32'(r_fcnt), 32'(frames & 16'hFFFF));
      if (b_done) pulses++;
   endtask

   // One clock: drive at negedge, advance the model at the edge, check at
   // the next negedge.
   task automatic cyc(input logic v, input logic [23:0] d, input logic pb,
                      output bit acc);
      bit do_push;
      bit do_pop;
      vld   = v;
      din   = d;
      pbusy = pb;
      do_push = v && q.size() < 2;
      do_pop  = q.size() != 0 && !pb;
      @(posedge clk);
      done_exp = 0;
      if (do_pop) begin
         if (q[0].eof) begin
            done_exp = 1;
            frames++;
         end
         void'(q.pop_front());
      end
      if (do_push) begin
         q.push_back(model(d, n_in));
         n_in++;
      end
      acc = do_push;
      @(negedge clk);
      check_out();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      vld = 1'b0;
      @(posedge clk);
      q.delete();
      n_in = 0;
      frames = 0;
      done_exp = 0;
      @(negedge clk);
      rst = 1'b0;
      check_out();
   endtask

   task automatic send(input int npix, input bit rnd_busy);
      int   sent;
      int   guard;
      bit   acc;
      logic [23:0] d;
      sent = 0;
      guard = 0;
      d = 24'($urandom);
      while (sent < npix && guard < 2000) begin
         cyc(1'b1, d, rnd_busy ? 1'($urandom_range(0, 1)) : 1'b0, acc);
         if (acc) begin
            sent++;
            d = 24'($urandom);
         end
         guard++;
      end
      if (guard >= 2000) chk("send_timeout", 32'(sent), 32'(npix));
   endtask

   task automatic drain();
      bit acc;
      for (int i = 0; i < 4; i++) cyc(1'b0, 24'($urandom), 1'b0, acc);
   endtask

   initial begin
      bit acc;
      rst = 1'b1;
      vld = 1'b0;
      din = '0;
      pbusy = 1'b0;
      n_in = 0;
      frames = 0;
      done_exp = 0;
      pulses = 0;
      @(negedge clk);
      do_reset();
      chk("rst_data", 32'(b_data), 32'h0);
      chk("rst_eol", 32'(b_eol), 32'h0);
      chk("rst_eof", 32'(b_eof), 32'h0);

      // Threshold and raw magnitude
      cyc(1'b1, 24'h107F20, 1'b1, acc);
      chk("thr_lo_bin", 32'(b_data), 32'h00);
      chk("thr_lo_raw", 32'(r_data), 32'h7F);
      cyc(1'b0, 24'h0, 1'b0, acc);
      cyc(1'b1, 24'h000080, 1'b1, acc);
      chk("thr_hi_bin", 32'(b_data), 32'hFF);
      chk("thr_hi_raw", 32'(r_data), 32'h80);
      drain();

      // One full frame plus one pixel, no backpressure
      do_reset();
      pulses = 0;
      send(9, 0);
      drain();
      chk("frame1_cnt", 32'(b_fcnt), 32'd1);
      chk("frame1_pulses", 32'(pulses), 32'd1);

      // Backpressure: buffer fills, head holds, then drains in order
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1'b1, 24'($urandom), 1'b1, acc);
      chk("bp_busy", 32'(b_busy), 32'd1);
      drain();

      // Push and pop together at count 1
      do_reset();
      cyc(1'b1, 24'($urandom), 1'b1, acc);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 24'($urandom), 1'b0, acc);
         chk("pp_busy", 32'(b_busy), 32'd0);
         chk("pp_vld", 32'(b_vld), 32'd1);
      end
      drain();

      // Reset mid-frame with a pixel buffered
      do_reset();
      send(4, 0);
      cyc(1'b1, 24'($urandom), 1'b1, acc);
      do_reset();
      chk("mid_rst_vld", 32'(b_vld), 32'd0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 24'($urandom), 1'b0, acc);
         chk("mid_rst_eol", 32'(b_eol), 32'(i == 3));
      end
      drain();
      chk("mid_rst_fcnt", 32'(b_fcnt), 32'd0);

      // Back-to-back frames with random backpressure
      do_reset();
      pulses = 0;
      send(24, 1);
      drain();
      chk("b2b_fcnt", 32'(b_fcnt), 32'd3);
      chk("b2b_pulses", 32'(pulses), 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
